// File: rtl/mc_core_hs.sv
// ============================================================================
// Module   : mc_core_hs
// Purpose  : Multicycle RV-subset core (FETCH/DECODE/EXEC/MEM/WB/HALT) with
//            XLEN-wide datapath and req/ack handshake memory ports.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock       in   rising-edge system clock
//   reset       in   asynchronous active-low reset
//   imem_req    out  instruction fetch request (held until imem_ack)
//   imem_addr   out  fetch address (= PC)
//   imem_rdata  in   instruction word, valid with imem_ack
//   imem_ack    in   fetch completes this cycle
//   dmem_req    out  data access request (held until dmem_ack)
//   dmem_we     out  1 = store, 0 = load
//   dmem_addr   out  data address
//   dmem_wdata  out  store data (rs2)
//   dmem_rdata  in   load data, valid with dmem_ack
//   dmem_ack    in   data access completes this cycle
//   pc          out  current PC
//   retire      out  one-cycle pulse per completed instruction
//   halted      out  core is in HALT
//   trap        out  HALT caused by illegal/misaligned event (0 for ebreak)
// ============================================================================
`default_nettype none

module mc_core_hs #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ack,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic [XLEN-1:0] pc,
  output logic            retire,
  output logic            halted,
  output logic            trap
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_st_fetch  = 3'd0;
  localparam logic [2:0] c_st_decode = 3'd1;
  localparam logic [2:0] c_st_exec   = 3'd2;
  localparam logic [2:0] c_st_mem    = 3'd3;
  localparam logic [2:0] c_st_wb     = 3'd4;
  localparam logic [2:0] c_st_halt   = 3'd5;

  localparam logic [6:0] c_op_r      = 7'b0110011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;

  localparam logic [31:0] c_ebreak   = 32'h0010_0073;

  // Doubleword accesses on RV64, word accesses on RV32.
  localparam logic [2:0] c_ls_f3     = (XLEN == 64) ? 3'b011 : 3'b010;
  localparam logic [2:0] c_align_msk = (XLEN == 64) ? 3'b111 : 3'b011;

  localparam logic [XLEN-1:0] c_four = XLEN'(4);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [2:0]                r_state;
  logic [XLEN-1:0]           r_pc;
  logic [31:0]               r_ir;
  logic [XLEN-1:0]           r_a;
  logic [XLEN-1:0]           r_b;
  logic [XLEN-1:0]           r_imm;
  logic [XLEN-1:0]           r_target;
  logic [XLEN-1:0]           r_alu;
  logic [XLEN-1:0]           r_mdr;
  logic [XLEN-1:0]           r_next_pc;
  logic                      r_trap;
  // Entry 0 is reset to zero and never written, so it always reads as x0=0.
  logic [31:0][XLEN-1:0]     r_regs;

  // --------------------------------------------------------------------------
  // Instruction field decode (IR is stable from DECODE through WB)
  // --------------------------------------------------------------------------
  logic [6:0]      w_opcode;
  logic [4:0]      w_rd;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;

  assign w_opcode = r_ir[6:0];
  assign w_rd     = r_ir[11:7];
  assign w_f3     = r_ir[14:12];
  assign w_rs1    = r_ir[19:15];
  assign w_rs2    = r_ir[24:20];
  assign w_f7     = r_ir[31:25];

  logic w_is_alu_r;
  logic w_is_addi;
  logic w_is_load;
  logic w_is_store;
  logic w_is_branch;
  logic w_is_lui;
  logic w_is_jal;
  logic w_is_ebreak;
  logic w_legal;
  logic w_writes_rd;

  assign w_is_alu_r  = (w_opcode == c_op_r) &&
                       (((w_f3 == 3'b000) && ((w_f7 == 7'b0000000) || (w_f7 == 7'b0100000))) ||
                        (((w_f3 == 3'b111) || (w_f3 == 3'b110)) && (w_f7 == 7'b0000000)));
  assign w_is_addi   = (w_opcode == c_op_imm)    && (w_f3 == 3'b000);
  assign w_is_load   = (w_opcode == c_op_load)   && (w_f3 == c_ls_f3);
  assign w_is_store  = (w_opcode == c_op_store)  && (w_f3 == c_ls_f3);
  assign w_is_branch = (w_opcode == c_op_branch) && ((w_f3 == 3'b000) || (w_f3 == 3'b001));
  assign w_is_lui    = (w_opcode == c_op_lui);
  assign w_is_jal    = (w_opcode == c_op_jal);
  assign w_is_ebreak = (r_ir == c_ebreak);

  assign w_legal     = w_is_alu_r | w_is_addi | w_is_load | w_is_store |
                       w_is_branch | w_is_lui | w_is_jal;
  assign w_writes_rd = w_is_alu_r | w_is_addi | w_is_load | w_is_lui | w_is_jal;

  // --------------------------------------------------------------------------
  // Immediates, all sign-extended to XLEN
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_imm;

  assign w_imm_i = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};
  assign w_imm_s = {{(XLEN-12){r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
  assign w_imm_b = {{(XLEN-12){r_ir[31]}}, r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
  assign w_imm_u = {{(XLEN-31){r_ir[31]}}, r_ir[30:12], 12'b0};
  assign w_imm_j = {{(XLEN-20){r_ir[31]}}, r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};

  always_comb begin
    w_imm = w_imm_i;
    if (w_opcode == c_op_store) begin
      w_imm = w_imm_s;
    end else if (w_opcode == c_op_branch) begin
      w_imm = w_imm_b;
    end else if (w_opcode == c_op_lui) begin
      w_imm = w_imm_u;
    end else if (w_opcode == c_op_jal) begin
      w_imm = w_imm_j;
    end
  end

  // --------------------------------------------------------------------------
  // Operand read and execute datapath
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_alu;
  logic            w_taken;
  logic            w_ls_misaligned;

  assign w_rs1_val  = r_regs[w_rs1];
  assign w_rs2_val  = r_regs[w_rs2];
  assign w_pc_plus4 = r_pc + c_four;

  // Default path is A+imm, which covers addi and the load/store address.
  always_comb begin
    w_alu = r_a + r_imm;
    if (w_is_alu_r) begin
      case (w_f3)
        3'b111:  w_alu = r_a & r_b;
        3'b110:  w_alu = r_a | r_b;
        default: w_alu = w_f7[5] ? (r_a - r_b) : (r_a + r_b);
      endcase
    end else if (w_is_lui) begin
      w_alu = r_imm;
    end else if (w_is_jal) begin
      w_alu = w_pc_plus4;
    end
  end

  // f3[0] distinguishes bne from beq.
  assign w_taken         = w_is_jal || (w_is_branch && ((r_a == r_b) ^ w_f3[0]));
  assign w_ls_misaligned = ((w_alu[2:0] & c_align_msk) != 3'b000);

  // --------------------------------------------------------------------------
  // Control FSM and architectural state
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= c_st_fetch;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_imm     <= '0;
      r_target  <= '0;
      r_alu     <= '0;
      r_mdr     <= '0;
      r_next_pc <= '0;
      r_trap    <= 1'b0;
      r_regs    <= '0;
    end else begin
      case (r_state)
        c_st_fetch: begin
          if (imem_ack) begin
            r_ir    <= imem_rdata;
            r_state <= c_st_decode;
          end
        end

        c_st_decode: begin
          r_a      <= w_rs1_val;
          r_b      <= w_rs2_val;
          r_imm    <= w_imm;
          r_target <= r_pc + w_imm;
          if (w_is_ebreak) begin
            r_trap  <= 1'b0;
            r_state <= c_st_halt;
          end else if (!w_legal) begin
            r_trap  <= 1'b1;
            r_state <= c_st_halt;
          end else begin
            r_state <= c_st_exec;
          end
        end

        c_st_exec: begin
          r_alu     <= w_alu;
          r_next_pc <= w_pc_plus4;
          if (w_is_load || w_is_store) begin
            // A misaligned access halts before any request reaches the bus.
            if (w_ls_misaligned) begin
              r_trap  <= 1'b1;
              r_state <= c_st_halt;
            end else begin
              r_state <= c_st_mem;
            end
          end else if (w_taken && r_target[1]) begin
            // Misaligned control transfer: leave PC and rd untouched.
            r_trap  <= 1'b1;
            r_state <= c_st_halt;
          end else begin
            if (w_taken) begin
              r_next_pc <= r_target;
            end
            r_state <= c_st_wb;
          end
        end

        c_st_mem: begin
          if (dmem_ack) begin
            if (w_is_load) begin
              r_mdr <= dmem_rdata;
            end
            r_state <= c_st_wb;
          end
        end

        c_st_wb: begin
          if (w_writes_rd && (w_rd != 5'd0)) begin
            r_regs[w_rd] <= w_is_load ? r_mdr : r_alu;
          end
          r_pc    <= r_next_pc;
          r_state <= c_st_fetch;
        end

        c_st_halt: begin
          r_state <= c_st_halt;
        end

        default: begin
          r_trap  <= 1'b1;
          r_state <= c_st_halt;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // The FSM sits in FETCH while reset is held, so the fetch request is
  // additionally gated by reset to keep it low until release.
  assign imem_req   = reset && (r_state == c_st_fetch);
  assign imem_addr  = r_pc;
  assign dmem_req   = (r_state == c_st_mem);
  assign dmem_we    = (r_state == c_st_mem) && w_is_store;
  assign dmem_addr  = r_alu;
  assign dmem_wdata = r_b;
  assign pc         = r_pc;
  assign retire     = (r_state == c_st_wb);
  assign halted     = (r_state == c_st_halt);
  assign trap       = r_trap;

endmodule

`default_nettype wire

// File: tb/tb_mc_core_hs.sv
// ============================================================================
// Module   : tb_mc_core_hs
// Purpose  : Self-checking bench for mc_core_hs (XLEN=64, RESET_PC=0x100).
//            Programs are placed in a bench instruction memory; expected
//            retire events and data-bus transactions are queued as each
//            instruction is placed and compared when the core produces them.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_core_hs;

  localparam int          XLEN = 64;
  localparam logic [63:0] RPC  = 64'h100;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [63:0] dmem_rdata;
  logic        dmem_ack;
  logic [63:0] pc;
  logic        retire;
  logic        halted;
  logic        trap;

  mc_core_hs #(.XLEN(XLEN), .RESET_PC(RPC)) u_dut (
    .clock      (clk),
    .reset      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .pc         (pc),
    .retire     (retire),
    .halted     (halted),
    .trap       (trap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Scoreboard queues
  // --------------------------------------------------------------------------
  typedef struct {
    logic [63:0] pc;
    int          lat;
  } rexp_t;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] data;
    int          cyc;
  } mexp_t;

  rexp_t rq[$];
  mexp_t mq[$];

  // --------------------------------------------------------------------------
  // Memories and program builder
  // --------------------------------------------------------------------------
  logic [31:0] imem_m [256];
  logic [63:0] dmem_m [64];
  logic [63:0] bpc;
  int          dwait;
  int          dreq_seen;

  function automatic logic [31:0] e_i(input int imm, input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] op);
    logic [31:0] m;
    m = imm;
    return {m[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] e_r(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] e_sd(input logic [4:0] rs2, input logic [4:0] rs1, input int imm);
    logic [31:0] m;
    m = imm;
    return {m[11:5], rs2, rs1, 3'b011, m[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] e_b(input logic [2:0] f3, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input int imm);
    logic [31:0] m;
    m = imm;
    return {m[12], m[10:5], rs2, rs1, f3, m[4:1], m[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] e_jal(input logic [4:0] rd, input int imm);
    logic [31:0] m;
    m = imm;
    return {m[20], m[10:1], m[11], m[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] e_addi(input logic [4:0] rd, input logic [4:0] rs1, input int imm);
    return e_i(imm, rs1, 3'b000, rd, 7'b0010011);
  endfunction

  function automatic logic [31:0] e_ld(input logic [4:0] rd, input logic [4:0] rs1, input int imm);
    return e_i(imm, rs1, 3'b011, rd, 7'b0000011);
  endfunction

  // Place an instruction and queue its expected retire (pc after, latency).
  task automatic put(input logic [31:0] ins, input int lat, input logic [63:0] nxt);
    imem_m[bpc[9:2]] = ins;
    rq.push_back('{nxt, lat});
    bpc = nxt;
  endtask

  // Place a load/store; queue the retire and the bus transaction.
  task automatic put_mem(input logic [31:0] ins, input logic we, input logic [63:0] addr,
                         input logic [63:0] data);
    mq.push_back('{we, addr, data, dwait + 1});
    put(ins, 5 + dwait, bpc + 64'd4);
  endtask

  task automatic raw(input logic [31:0] ins);
    imem_m[bpc[9:2]] = ins;
    bpc = bpc + 64'd4;
  endtask

  task automatic fill_imem();
    for (int i = 0; i < 256; i++) imem_m[i] = 32'h0000_007F;
    bpc = RPC;
  endtask

  // --------------------------------------------------------------------------
  // Memory responders: drive inputs 1 time unit after each rising edge
  // --------------------------------------------------------------------------
  initial begin
    int wcnt;
    wcnt       = 0;
    imem_ack   = 1'b1;
    imem_rdata = '0;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      imem_rdata = imem_m[imem_addr[9:2]];
      if (dmem_req) begin
        if (wcnt >= dwait) begin
          dmem_ack   = 1'b1;
          dmem_rdata = dmem_m[dmem_addr[8:3]];
          wcnt       = 0;
        end else begin
          dmem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        dmem_ack = 1'b0;
        wcnt     = 0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output monitor, sampled on the falling edge
  // --------------------------------------------------------------------------
  initial begin
    int          cyc;
    int          req_cnt;
    bit          pc_pend;
    logic [63:0] exp_pc;
    rexp_t       re;
    mexp_t       me;
    cyc     = 0;
    req_cnt = 0;
    pc_pend = 0;
    exp_pc  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cyc     = 0;
        req_cnt = 0;
        pc_pend = 0;
      end else begin
        cyc++;
        if (pc_pend) begin
          chk("pc_after_retire", pc, exp_pc);
          pc_pend = 0;
        end
        if (dmem_req) begin
          req_cnt++;
          dreq_seen++;
        end
        if (dmem_req && dmem_ack) begin
          if (mq.size() == 0) begin
            chk("mem_unexpected", 64'd1, 64'd0);
          end else begin
            me = mq.pop_front();
            chk("mem_we", {63'd0, dmem_we}, {63'd0, me.we});
            chk("mem_addr", dmem_addr, me.addr);
            if (me.we) chk("mem_wdata", dmem_wdata, me.data);
            chk("mem_req_cycles", 64'(req_cnt), 64'(me.cyc));
          end
          if (dmem_we) dmem_m[dmem_addr[8:3]] = dmem_wdata;
          req_cnt = 0;
        end
        if (retire) begin
          if (rq.size() == 0) begin
            chk("retire_unexpected", 64'd1, 64'd0);
          end else begin
            re = rq.pop_front();
            chk("retire_latency", 64'(cyc), 64'(re.lat));
            exp_pc  = re.pc;
            pc_pend = 1;
          end
          cyc = 0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Phase helpers
  // --------------------------------------------------------------------------
  task automatic start_phase();
    rst_n = 1'b0;
    #1;
    chk("rst_imem_req", {63'd0, imem_req}, 64'd0);
    chk("rst_dmem_req", {63'd0, dmem_req}, 64'd0);
    chk("rst_dmem_we", {63'd0, dmem_we}, 64'd0);
    chk("rst_retire", {63'd0, retire}, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    chk("rst_trap", {63'd0, trap}, 64'd0);
    chk("rst_pc", pc, RPC);
    chk("rst_imem_addr", imem_addr, RPC);
  endtask

  task automatic release_rst();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic wait_halt(input int bound);
    for (int i = 0; i < bound && !halted; i++) @(negedge clk);
    chk("halted", {63'd0, halted}, 64'd1);
  endtask

  task automatic check_queues_empty(input string tag);
    chk({tag, "_retire_q_empty"}, 64'(rq.size()), 64'd0);
    chk({tag, "_mem_q_empty"}, 64'(mq.size()), 64'd0);
    rq.delete();
    mq.delete();
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  logic [31:0] trap_ins [3];

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b1;
    dwait     = 0;
    dreq_seen = 0;
    for (int i = 0; i < 64; i++) dmem_m[i] = '0;
    #2;

    // ---------------- Phase 1: first fetch, ALU, branches, jal, ebreak ----
    start_phase();
    fill_imem();
    dwait = 0;
    put(e_addi(1, 0, 5), 4, 64'h104);
    put(e_addi(1, 0, -3), 4, 64'h108);
    put(e_addi(2, 0, 7), 4, 64'h10C);
    put(e_r(7'b0000000, 3'b000, 3, 1, 2), 4, 64'h110);          // add x3 = 4
    put(e_r(7'b0100000, 3'b000, 4, 1, 2), 4, 64'h114);          // sub x4 = -10
    put(e_addi(0, 0, 9), 4, 64'h118);                           // x0 stays 0
    put_mem(e_sd(3, 0, 0), 1'b1, 64'd0, 64'd4);
    put_mem(e_sd(4, 0, 8), 1'b1, 64'd8, 64'hFFFF_FFFF_FFFF_FFF6);
    put_mem(e_sd(0, 0, 16), 1'b1, 64'd16, 64'd0);
    put({20'h80000, 5'd7, 7'b0110111}, 4, 64'h128);             // lui x7
    put_mem(e_sd(7, 0, 24), 1'b1, 64'd24, 64'hFFFF_FFFF_8000_0000);
    put(e_r(7'b0000000, 3'b111, 8, 1, 2), 4, 64'h130);          // and -> 5
    put(e_r(7'b0000000, 3'b110, 9, 1, 2), 4, 64'h134);          // or  -> -1
    put_mem(e_sd(8, 0, 32), 1'b1, 64'd32, 64'd5);
    put_mem(e_sd(9, 0, 40), 1'b1, 64'd40, 64'hFFFF_FFFF_FFFF_FFFF);
    put(e_b(3'b000, 1, 1, 8), 4, 64'h144);                      // beq taken
    put(e_b(3'b001, 1, 1, 8), 4, 64'h148);                      // bne not taken
    put(e_jal(0, 32'h200 - 32'h148), 4, 64'h200);
    put(e_jal(6, -4), 4, 64'h1FC);                              // x6 = 0x204
    put(e_jal(0, 32'h24), 4, 64'h220);
    put_mem(e_sd(6, 0, 48), 1'b1, 64'd48, 64'h204);
    raw(32'h0010_0073);                                         // ebreak
    release_rst();
    @(negedge clk);
    chk("first_imem_req", {63'd0, imem_req}, 64'd1);
    chk("first_imem_addr", imem_addr, RPC);
    wait_halt(400);
    chk("ebreak_trap", {63'd0, trap}, 64'd0);
    chk("ebreak_pc", pc, 64'h224);
    check_queues_empty("p1");

    // ---------------- Phase 2: load/store with 3 wait states --------------
    start_phase();
    fill_imem();
    dwait = 3;
    put(e_addi(3, 0, 4), 4, 64'h104);
    put_mem(e_sd(3, 0, 8), 1'b1, 64'd8, 64'd4);
    put_mem(e_ld(5, 0, 8), 1'b0, 64'd8, 64'd0);
    put_mem(e_sd(5, 0, 16), 1'b1, 64'd16, 64'd4);               // x5 == 4
    raw(32'h0010_0073);
    release_rst();
    wait_halt(200);
    chk("p2_trap", {63'd0, trap}, 64'd0);
    chk("p2_pc", pc, 64'h110);
    check_queues_empty("p2");

    // ---------------- Phase 3: traps --------------------------------------
    trap_ins[0] = e_ld(5, 0, 4);                                // misaligned ld
    trap_ins[1] = 32'h0000_007F;                                // illegal opcode
    trap_ins[2] = e_b(3'b000, 0, 0, 6);                         // target bit1 set
    for (int k = 0; k < 3; k++) begin
      start_phase();
      fill_imem();
      dwait = 0;
      imem_m[RPC[9:2]] = trap_ins[k];
      dreq_seen = 0;
      release_rst();
      wait_halt(50);
      chk("trap_flag", {63'd0, trap}, 64'd1);
      chk("trap_pc", pc, RPC);
      repeat (3) @(negedge clk);
      chk("halt_hold", {63'd0, halted}, 64'd1);
      chk("halt_no_imem_req", {63'd0, imem_req}, 64'd0);
      chk("halt_pc_frozen", pc, RPC);
      chk("trap_no_dmem_req", 64'(dreq_seen), 64'd0);
      check_queues_empty("p3");
    end

    // ---------------- Phase 4: reset during a pending data access ---------
    start_phase();
    fill_imem();
    dwait = 1000;
    put(e_addi(3, 0, 4), 4, 64'h104);
    raw(e_sd(3, 0, 16));                                        // never acked
    release_rst();
    for (int i = 0; i < 40 && !dmem_req; i++) @(negedge clk);
    chk("mm_req_seen", {63'd0, dmem_req}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mm_dmem_req_drop", {63'd0, dmem_req}, 64'd0);
    chk("mm_pc_reset", pc, RPC);
    chk("mm_retire", {63'd0, retire}, 64'd0);
    check_queues_empty("p4a");
    fill_imem();
    dwait = 0;
    put_mem(e_sd(3, 0, 24), 1'b1, 64'd24, 64'd0);               // x3 cleared
    raw(32'h0010_0073);
    release_rst();
    wait_halt(100);
    chk("mm_trap", {63'd0, trap}, 64'd0);
    chk("mm_final_pc", pc, 64'h104);
    check_queues_empty("p4b");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mc_core_hs.md
Name: mc_core_hs

Overview:
- Parametrised successor to the fixed-memory multicycle RISC-V datapath top.
- Merges datapath and control FSM into one block, generalised in XLEN.
- Replaces the fixed-latency instruction/data memories with req/ack handshake ports, so wait-state memories or a shared bus can be attached.
- Adds halt/trap reporting and a retire strobe for bench and debug visibility.

Parameters:
XLEN, 64, datapath and register width; legal values 32 or 64.
RESET_PC, 0, PC value loaded on reset.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
imem_req  output  1  instruction fetch request.
imem_addr  output  XLEN  fetch address, equal to PC.
imem_rdata  input  32  instruction word; valid when imem_ack=1.
imem_ack  input  1  fetch completes in this cycle.
dmem_req  output  1  data access request.
dmem_we  output  1  1=store, 0=load.
dmem_addr  output  XLEN  data address.
dmem_wdata  output  XLEN  store data (rs2).
dmem_rdata  input  XLEN  load data; valid when dmem_ack=1.
dmem_ack  input  1  data access completes in this cycle.
pc  output  XLEN  current PC.
retire  output  1  one-cycle pulse per completed instruction.
halted  output  1  core is in HALT.
trap  output  1  halt was caused by an illegal or misaligned event (0 for ebreak).

Behaviour:
- Reset (reset=0, asynchronous):
  - PC=RESET_PC, state=FETCH, all regs x1..x31=0.
  - All outputs deassert, except pc=RESET_PC and imem_addr=RESET_PC.
  - Reset asserted mid-transaction aborts the transaction immediately; no partial writes.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: imem_req=1 is held until imem_ack=1. On ack, latch the IR and go to DECODE.
- DECODE: read rs1/rs2 into A/B and build the immediate (I/S/B/U/J).
  - Illegal encoding -> HALT with trap=1.
  - ebreak (0x00100073) -> HALT with trap=0.
- EXEC: ALU operation.
  - ld/sd -> MEM. If the address is not aligned to XLEN/8, go to HALT with trap=1 and do not assert dmem_req.
  - beq/bne: the target is computed in DECODE. Taken branch -> PC=target, else PC+4. Then WB.
  - jal: rd=PC+4, PC=PC+imm, then WB.
  - A taken target with bit1 set -> HALT with trap=1; PC and rd are unchanged.
- MEM: dmem_req=1 is held, with addr/we/wdata stable, until dmem_ack=1.
  - Store: completes in the ack cycle.
  - Load: latches dmem_rdata into MDR.
- WB:
  - Write rd if the instruction writes rd and rd!=0.
  - PC update for non-branch instructions: PC=PC+4.
  - retire=1 for this single cycle. Next state is FETCH.
- Supported instructions:
  - R (0110011): add/sub (f3=000, f7=0000000/0100000), and (111), or (110).
  - addi (0010011, f3=000).
  - Load (0000011) and store (0100011) with f3=011 if XLEN=64, 010 if XLEN=32.
  - beq/bne (1100011, f3=000/001), lui (0110111), jal (1101111).
  - Anything else is illegal.
- Arithmetic:
  - Wraps modulo 2^XLEN; no overflow detection.
  - Immediates are sign-extended to XLEN.
  - lui: imm[31:12]<<12, then sign-extended.
- x0 reads 0 and writes to it are dropped.
- Latency with zero-wait memories:
  - ALU, branch, jal, lui: 4 cycles (F, D, E, WB).
  - Load/store: 5 cycles.
  - Each wait cycle on ack adds 1 cycle.
- HALT: absorbing until reset. No requests are issued, pc is frozen, halted=1.
- An ack arriving while the corresponding req=0 is ignored.

Test Plan:
- Reset and first fetch: release reset with RESET_PC=0x100, imem_ack tied 1 -> first imem_req with imem_addr=0x100; after addi x1,x0,5 completes, retire has pulsed once and pc=0x104.
- ALU sequence: addi x1,x0,-3; addi x2,x0,7; add x3,x1,x2; sub x4,x1,x2 -> x3=4, x4=0xFFFF_FFFF_FFFF_FFF6; addi x0,x0,9 leaves x0=0; each instruction takes 4 cycles.
- Load/store with wait states:
  - Setup: dmem_ack delayed 3 cycles.
  - Stimulus: sd x3,8(x0), then ld x5,8(x0).
  - Required: dmem_addr=8, dmem_wdata=4, req held for 4 cycles, x5=4, load takes 8 cycles total.
- Branches and jal: beq x1,x1,+8 -> pc advances 8; bne x1,x1,+8 -> pc advances 4; jal x6,-4 at 0x200 -> x6=0x204, pc=0x1FC.
- Traps:
  - ld at address 0x4 (XLEN=64) -> halted=1, trap=1, no dmem_req ever asserted.
  - Opcode 0x0000007F -> halted=1, trap=1.
  - ebreak -> halted=1, trap=0.
- Reset mid-MEM: assert reset while dmem_req=1 and ack is pending -> dmem_req drops asynchronously, pc=RESET_PC, register file is cleared, the core resumes fetching after release.
